// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and baud helpers for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Rounded-to-nearest divider so the bit period error stays under half a clock
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Narrower payloads are zero-extended; the extra zeros do not change the XOR
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter emitting a one-cycle bit_end pulse
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - lock-gated byte-wide UART transmitter with configurable parity and stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int         CPB       = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  logic                 lock_meta, lock_s;
  uart_state_e          state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [2:0]           bit_cnt, bit_cnt_d;
  logic                 stop_cnt, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 txd_d;
  logic                 bit_end, frame_last, accept, baud_clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Counter is held at zero while idle so every frame starts on a fresh bit period
  assign baud_clear = accept || (state == ST_IDLE);

  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  assign frame_last = (state == ST_STOP) && bit_end && (stop_cnt == LAST_STOP);
  assign tx_ready   = lock_s && ((state == ST_IDLE) || frame_last);
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_d      = par_q;
    txd_d      = 1'b1;

    case (state)
      ST_IDLE: ;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg >> 1;
          if (bit_cnt == LAST_BIT) begin
            state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (frame_last) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new byte may land in IDLE or in the final stop cycle for a gapless follow-on frame
    if (accept) begin
      state_d   = ST_START;
      shreg_d   = tx_data;
      bit_cnt_d = '0;
      par_d     = parity_bit(8'(tx_data), PARITY);
    end

    // txd is derived from the next state so the registered line changes with the state
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_q    <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      par_q    <= par_d;
      txd      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed and randomized bench for uart_tx against a frame-level line model
module tb_uart_tx;

  localparam int CPB = 217;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic [7:0] tx_data, tx_data_p;
  logic       tx_valid, tx_valid_e, tx_valid_o;
  logic       tx_ready, tx_ready_e, tx_ready_o;
  logic       txd, txd_e, txd_o;
  logic       busy, busy_e, busy_o;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  uart_tx #(.PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .busy(busy)
  );

  uart_tx #(.PARITY(2), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .tx_data(tx_data_p),
    .tx_valid(tx_valid_e), .tx_ready(tx_ready_e), .txd(txd_e), .busy(busy_e)
  );

  uart_tx #(.PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .tx_data(tx_data_p),
    .tx_valid(tx_valid_o), .tx_ready(tx_ready_o), .txd(txd_o), .busy(busy_o)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic rd_txd(input int inst);
    case (inst)
      0:       return txd;
      1:       return txd_e;
      default: return txd_o;
    endcase
  endfunction

  function automatic logic rd_ready(input int inst);
    case (inst)
      0:       return tx_ready;
      1:       return tx_ready_e;
      default: return tx_ready_o;
    endcase
  endfunction

  function automatic logic rd_busy(input int inst);
    case (inst)
      0:       return busy;
      1:       return busy_e;
      default: return busy_o;
    endcase
  endfunction

  // Line level for bit slot idx of a frame: start, 8 data LSB first, optional parity, stops
  function automatic logic exp_bit(input logic [7:0] d, input int par, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (par != 0 && idx == 9) begin
      ones = $countones(d);
      return (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
    end
    return 1'b1;
  endfunction

  // Presents a byte and returns at the negedge just after the accepting edge
  task automatic send(input int inst, input logic [7:0] d, input bit hold);
    int k;
    if (inst == 0) tx_data = d; else tx_data_p = d;
    case (inst)
      0:       tx_valid   = 1'b1;
      1:       tx_valid_e = 1'b1;
      default: tx_valid_o = 1'b1;
    endcase
    k = 0;
    while (rd_ready(inst) !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("accept_wait_i%0d", inst), rd_ready(inst), 1'b1);
    @(negedge clk);
    if (!hold) begin
      tx_valid   = 1'b0;
      tx_valid_e = 1'b0;
      tx_valid_o = 1'b0;
    end
  endtask

  task automatic check_frame(input int inst, input logic [7:0] d, input int par, input int nstop,
                             input int drop_at, input int exp_last_ready, input string tag);
    int len, rdy_low, busy_bad, mism, cyc;
    len      = 1 + 8 + ((par != 0) ? 1 : 0) + nstop;
    rdy_low  = 0;
    busy_bad = 0;
    for (int idx = 0; idx < len; idx++) begin
      mism = 0;
      for (int c = 0; c < CPB; c++) begin
        cyc = idx * CPB + c;
        if (cyc == drop_at) pll_locked = 1'b0;
        if (rd_txd(inst) !== exp_bit(d, par, idx)) mism++;
        if (rd_ready(inst) !== 1'b1) rdy_low++;
        if (rd_busy(inst) !== 1'b1) busy_bad++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d_mismatches", tag, idx), mism, 0);
    end
    check($sformatf("%s_ready_low_cycles", tag), rdy_low, len * CPB - exp_last_ready);
    check($sformatf("%s_busy_drops", tag), busy_bad, 0);
  endtask

  initial begin
    logic [7:0] d;
    int         bad_ready, bad_busy;

    rst_n      = 1'b0;
    pll_locked = 1'b1;
    tx_data    = 8'h00;
    tx_data_p  = 8'h00;
    tx_valid   = 1'b0;
    tx_valid_e = 1'b0;
    tx_valid_o = 1'b0;

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_txd_i%0d", i), rd_txd(i), 1'b1);
      check($sformatf("rst_ready_i%0d", i), rd_ready(i), 1'b0);
      check($sformatf("rst_busy_i%0d", i), rd_busy(i), 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_1_edge", tx_ready, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("ready_after_2_edges_i%0d", i), rd_ready(i), 1'b1);

    send(0, 8'h55, 1'b0);
    check_frame(0, 8'h55, 0, 1, -1, 1, "f55");
    repeat (3) @(negedge clk);
    check("idle_txd", txd, 1'b1);
    check("idle_busy", busy, 1'b0);

    send(0, 8'hA3, 1'b1);
    tx_data = 8'h0F;
    check_frame(0, 8'hA3, 0, 1, -1, 1, "fA3");
    tx_valid = 1'b0;
    check_frame(0, 8'h0F, 0, 1, -1, 1, "f0F_b2b");

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send(0, d, 1'b0);
      check_frame(0, d, 0, 1, -1, 1, $sformatf("rnd%0d_%02h", i, d));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    send(1, 8'h07, 1'b0);
    check_frame(1, 8'h07, 2, 2, -1, 1, "even07");
    send(2, 8'h07, 1'b0);
    check_frame(2, 8'h07, 1, 1, -1, 1, "odd07");
    d = 8'($urandom_range(0, 255));
    send(1, d, 1'b0);
    check_frame(1, d, 2, 2, -1, 1, $sformatf("even_%02h", d));
    d = 8'($urandom_range(0, 255));
    send(2, d, 1'b0);
    check_frame(2, d, 1, 1, -1, 1, $sformatf("odd_%02h", d));

    d = 8'($urandom_range(0, 255));
    send(0, d, 1'b0);
    check_frame(0, d, 0, 1, 500, 0, $sformatf("lockdrop_%02h", d));
    tx_valid  = 1'b1;
    tx_data   = 8'($urandom_range(0, 255));
    bad_ready = 0;
    bad_busy  = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_ready !== 1'b0) bad_ready++;
      if (busy !== 1'b0 || txd !== 1'b1) bad_busy++;
      @(negedge clk);
    end
    check("unlocked_ready_high", bad_ready, 0);
    check("unlocked_line_active", bad_busy, 0);
    tx_valid   = 1'b0;
    pll_locked = 1'b1;
    @(negedge clk);
    check("relock_ready_1_edge", tx_ready, 1'b0);
    @(negedge clk);
    check("relock_ready_2_edges", tx_ready, 1'b1);
    repeat (10) @(negedge clk);
    check("no_held_byte_busy", busy, 1'b0);
    check("no_held_byte_txd", txd, 1'b1);

    d = 8'($urandom_range(0, 255)) & 8'hF7;
    send(0, d, 1'b0);
    repeat (4 * CPB + 100) @(negedge clk);
    check("pre_reset_bit3_txd", txd, 1'b0);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_txd", txd, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", tx_ready, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_ready", tx_ready, 1'b1);
    d = 8'($urandom_range(0, 255));
    send(0, d, 1'b0);
    check_frame(0, d, 0, 1, -1, 1, $sformatf("post_reset_%02h", d));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
